// File: rtl/fir_decimate_requant.sv
// fir_decimate_requant
//
// Integrate-and-dump decimator behind the FIR filters. Every DECIM enabled
// input samples are summed, the sum is rounded (half toward +inf), shifted
// right by SHIFT, saturated to OUT_W bits and pushed into a small FIFO that
// feeds a valid/ready consumer.
//
// Ports:
//   clk                rising-edge clock
//   reset              asynchronous active-low reset
//   incoming_signal_y  signed full-precision FIR sample (IN_W)
//   sample_en          incoming_signal_y is valid this cycle
//   out_data           FIFO head (holds last popped value when empty)
//   out_valid          FIFO not empty
//   out_ready          consumer accepts out_data this cycle
//   fifo_level         FIFO occupancy
//   drop_count         results lost to a full FIFO, saturating
//   sat_flag           sticky: some result was clipped
module fir_decimate_requant #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [IN_W-1:0]        incoming_signal_y,
  input  logic                          sample_en,
  output logic signed [OUT_W-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count,
  output logic                          sat_flag
);

  localparam int PH_W  = $clog2(DECIM);
  localparam int ACC_W = IN_W + PH_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;

  localparam logic [PH_W-1:0]      PH_LAST = PH_W'(DECIM - 1);
  localparam logic signed [ACC_W:0] RND    = (ACC_W+1)'(1) <<< (SHIFT - 1);
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Integrate and dump
  // ---------------------------------------------------------------------------
  logic [PH_W-1:0]         phase_q, phase_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] dump_sum_q, dump_sum_d;
  logic                    dump_v_q, dump_v_d;
  logic signed [ACC_W-1:0] x_ext;

  always_comb begin
    x_ext      = {{PH_W{incoming_signal_y[IN_W-1]}}, incoming_signal_y};
    phase_d    = phase_q;
    acc_d      = acc_q;
    dump_sum_d = dump_sum_q;
    dump_v_d   = 1'b0;
    if (sample_en) begin
      if (phase_q == '0) begin
        acc_d = x_ext;
      end else begin
        acc_d = acc_q + x_ext;
      end
      if (phase_q == PH_LAST) begin
        dump_sum_d = acc_q + x_ext;
        dump_v_d   = 1'b1;
        phase_d    = '0;
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round, shift, saturate
  // ---------------------------------------------------------------------------
  logic signed [ACC_W:0]   rnd_sum;
  logic signed [ACC_W:0]   r;
  logic                    sat_hi, sat_lo;
  logic signed [OUT_W-1:0] result;

  always_comb begin
    // One extra bit so adding the rounding constant can never wrap.
    rnd_sum = {dump_sum_q[ACC_W-1], dump_sum_q} + RND;
    r       = rnd_sum >>> SHIFT;
    // Value fits in OUT_W only if all bits from OUT_W-1 upward match the sign.
    sat_hi  = ~r[ACC_W] & (|r[ACC_W-1:OUT_W-1]);
    sat_lo  = r[ACC_W] & ~(&r[ACC_W-1:OUT_W-1]);
    if (sat_hi) begin
      result = OUT_MAX;
    end else if (sat_lo) begin
      result = OUT_MIN;
    end else begin
      result = r[OUT_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic signed [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic signed [OUT_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]           rd_ptr_nxt;
  logic [LW-1:0]           level_q, level_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic [15:0]             drop_q, drop_d;
  logic                    sat_q, sat_d;
  logic                    fifo_full, fifo_empty;
  logic                    push, pop, drop;

  always_comb begin
    fifo_full  = (level_q == LW'(FIFO_DEPTH));
    fifo_empty = (level_q == '0);
    pop        = ~fifo_empty & out_ready;
    // A full FIFO still takes the result when the head leaves in the same cycle.
    push       = dump_v_q & (~fifo_full | pop);
    drop       = dump_v_q & fifo_full & ~pop;
    rd_ptr_nxt = rd_ptr_q + AW'(1);

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    out_data_d = out_data_q;
    drop_d     = drop_q;
    sat_d      = sat_q | (dump_v_q & (sat_hi | sat_lo));

    if (push) begin
      mem_d[wr_ptr_q] = result;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_nxt;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // out_data is a register tracking the head; when the FIFO drains it keeps
    // the value just popped instead of exposing a stale memory slot.
    if (pop) begin
      if (level_q > LW'(1)) begin
        out_data_d = mem_q[rd_ptr_nxt];
      end else if (push) begin
        out_data_d = result;
      end
    end else if (push && fifo_empty) begin
      out_data_d = result;
    end

    if (drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q    <= '0;
      acc_q      <= '0;
      dump_sum_q <= '0;
      dump_v_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
      drop_q     <= '0;
      sat_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      dump_sum_q <= dump_sum_d;
      dump_v_q   <= dump_v_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_data_q <= out_data_d;
      drop_q     <= drop_d;
      sat_q      <= sat_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = (level_q != '0);
  assign fifo_level = level_q;
  assign drop_count = drop_q;
  assign sat_flag   = sat_q;

endmodule

// File: doc/fir_decimate_requant.md
# fir_decimate_requant

Downstream stage of the FIR filters. Takes the 32-bit full-precision filter output, integrates and dumps over DECIM samples, rounds and saturates the sum to OUT_W bits, and buffers results in a small FIFO behind a valid/ready output handshake. It reduces the sample rate and word width before results go to the consumer.

## Interface
- IN_W, 32: input sample width, signed two's complement.
- OUT_W, 16: output sample width, signed.
- DECIM, 4: samples summed per output, ≥2.
- SHIFT, 2: arithmetic right shift applied to the sum, ≥1.
- FIFO_DEPTH, 4: output FIFO entries, power of 2, ≥2.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- incoming_signal_y  in  IN_W  signed FIR output sample.
- sample_en  in  1  incoming_signal_y is a valid sample this cycle.
- out_data  out  OUT_W  FIFO head sample, signed.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  out  16  results discarded because the FIFO was full. Saturates at 16'hFFFF.
- sat_flag  out  1  sticky. Set when any result saturated. Cleared only by reset.

## Operation
- Phase counter runs 0..DECIM-1 and advances only when sample_en=1. It wraps to 0 after DECIM-1.
- Accumulator width is IN_W+$clog2(DECIM), signed, so it cannot overflow. Each sample is sign-extended before it is added.
  - On a phase-0 sample: acc <= x.
  - On other phases: acc <= acc + x.
- Dump: the phase DECIM-1 sample goes into dump_sum <= acc + x, and dump_v is pulsed for one cycle.
- Requant on dump_v (combinational from dump_sum):
  - r = (dump_sum + 2^(SHIFT-1)) >>> SHIFT, which rounds half toward +inf.
  - Add at width+1 so the rounding add cannot overflow.
  - If r > 2^(OUT_W-1)-1, result = max and sat_flag is set.
  - If r < -2^(OUT_W-1), result = min and sat_flag is set.
  - Otherwise result = r truncated to OUT_W.
- FIFO push: on dump_v, the result is written at the end of that cycle.
  - If the FIFO is full and there is no pop in the same cycle, the result is dropped and drop_count increments.
  - If the FIFO is full and a pop happens in the same cycle (out_valid & out_ready), the push is accepted and the level is unchanged.
- FIFO pop happens when out_valid & out_ready. Order is strictly first-in, first-out.
- out_data holds the current head when out_valid=1. It holds the last popped value (0 after reset) when the FIFO is empty. Its value is don't-care when out_valid=0, but it must not be X.
- Reset (asynchronous assert, synchronous-release usage):
  - phase, acc, dump_sum, dump_v, FIFO pointers, fifo_level, out_data, out_valid, drop_count and sat_flag all go to 0.
  - A partially accumulated sum is discarded. The first output after reset uses DECIM fresh samples.

## Timing
- Cycle N: the phase DECIM-1 sample is present with sample_en=1. At the edge ending N, dump_sum is captured and dump_v=1 during N+1.
- At the edge ending N+1, the result is written to the FIFO.
- With the FIFO empty, out_valid=1 and out_data is valid in cycle N+2. Latency is 2 clocks.
- Throughput is one input per clock. At most one output is produced every DECIM enabled samples.
- fifo_level and out_valid update at the same edge as the push or pop that changes them.
- sample_en=0 cycles freeze phase and acc. An in-flight dump_v still completes.
- out_ready has no combinational path to any input. out_valid depends only on registered state.

## Test plan
- **Constant input:** defaults, incoming_signal_y=100 with sample_en=1 continuously and out_ready=1 -> out_data=100 every 4th cycle. The first out_valid comes 2 cycles after the 4th sample. sat_flag=0 and drop_count=0.
- **Rounding:**
  - Sample groups {1,1,1,0}, {-1,-1,-1,-1} and {-1,-1,0,0} -> outputs 1, -1, 0 in that order.
  - Group {1,1,0,0} gives sum 2 -> output 1 (half rounds up).
- **Saturation:**
  - 4×40000 -> 32767 and sat_flag=1.
  - Then 4×-40000 -> -32768.
  - Then 4×5 -> 5, with sat_flag still 1.
- **Backpressure:** out_ready=0 while 6 results are produced -> fifo_level=4 and drop_count=2. Then out_ready=1 -> 4 pops in order of the first 4 results, then out_valid=0.
  - Also check full FIFO with a simultaneous pop and push -> no drop, level stays 4.
- **Enable gaps:** sample_en pattern 1,0,1,0,0,1,1 with value 8 -> a single output of 8, produced 2 cycles after the 4th enabled sample. Disabled values (e.g. 9999) must not affect it.
- **Reset mid-operation:**
  - Assert reset after 2 samples, with 2 results queued -> all outputs 0 immediately.
  - After release, 4×20 -> a single output of 20, with no contribution from pre-reset samples.
